input_debouncer: RTL and testbench

- Conditions the raw board inputs before they reach the buttons peripheral: 10 push inputs (5 buttons plus 5 joystick lines) and 8 DIP switches.
- Per bit: synchronises, debounces with a stable-count filter, and produces a clean level plus single-cycle rise/fall pulses.
- The buttons peripheral consumes `push_level_o`, `switch_level_o` and `push_rise_o`; interrupt generation is based on clean edges.
- Sits between the top-level pins and the buttons peripheral, in the CPU clock domain.

---
 rtl/io_pkg.sv | 31 +++
 rtl/input_debouncer_if.sv | 42 ++++
 rtl/debounce_bit.sv | 80 ++++++++
 rtl/input_debouncer.sv | 94 +++++++++
 tb/tb_input_debouncer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared board-I/O definitions used by the input debouncer and the buttons peripheral.
// Contents: default input counts, push-bit index map (MSB first), and a
// ceiling-log2 helper for sizing counters.
package io_pkg;

    localparam int unsigned N_PUSH_DEF = 10;
    localparam int unsigned N_SW_DEF   = 8;

    // Push bit positions, MSB first
    localparam int unsigned PUSH_TOP         = 9;
    localparam int unsigned PUSH_BOTTOM      = 8;
    localparam int unsigned PUSH_LEFT        = 7;
    localparam int unsigned PUSH_RIGHT       = 6;
    localparam int unsigned PUSH_CENTER      = 5;
    localparam int unsigned PUSH_JOY_UP      = 4;
    localparam int unsigned PUSH_JOY_DOWN    = 3;
    localparam int unsigned PUSH_JOY_LEFT    = 2;
    localparam int unsigned PUSH_JOY_RIGHT   = 1;
    localparam int unsigned PUSH_JOY_PRESSED = 0;

    // Number of bits needed to hold values 0..value-1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Pin-side / debouncer-side bundle for the input debouncer.
//   push_i, switch_i           : raw asynchronous board inputs
//   push_level_o, switch_level_o: debounced levels
//   push_rise_o, push_fall_o   : one-cycle edge pulses on debounced push levels
//   event_o                    : OR of push rise pulses
// master = pin/consumer side, slave = debouncer.
interface input_debouncer_if
    import io_pkg::*;
#(
    parameter int unsigned N_PUSH = N_PUSH_DEF,
    parameter int unsigned N_SW   = N_SW_DEF
);

    logic [N_PUSH-1:0] push_i;
    logic [N_SW-1:0]   switch_i;
    logic [N_PUSH-1:0] push_level_o;
    logic [N_PUSH-1:0] push_rise_o;
    logic [N_PUSH-1:0] push_fall_o;
    logic [N_SW-1:0]   switch_level_o;
    logic              event_o;

    modport master (
        output push_i,
        output switch_i,
        input  push_level_o,
        input  push_rise_o,
        input  push_fall_o,
        input  switch_level_o,
        input  event_o
    );

    modport slave (
        input  push_i,
        input  switch_i,
        output push_level_o,
        output push_rise_o,
        output push_fall_o,
        output switch_level_o,
        output event_o
    );

endinterface

// File: rtl/debounce_bit.sv
// One-bit input conditioner: two-flop synchroniser, stable-count filter and
// registered rise/fall pulses.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   tick_i        : filter sample qualifier from the shared prescaler
//   raw_i         : asynchronous raw input
//   level_o       : debounced level
//   rise_o/fall_o : one-cycle pulses coincident with the level change
//   rise_next_c   : combinational rise pulse one cycle early (for shared event flop)
module debounce_bit
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic rise_next_c
);

    localparam int unsigned      CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Next-state: any agreement with the stable level wipes progress, so a
    // single-cycle glitch restarts the whole window.
    always_comb begin
        s1_d     = raw_i;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                cnt_d    = '0;
                rise_d   = s2_q;
                fall_d   = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level_o     = stable_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign rise_next_c = rise_d;

endmodule

// File: rtl/input_debouncer.sv
// Board input conditioner: synchronises and debounces N_PUSH push inputs and
// N_SW DIP switches, producing clean levels, push edge pulses and an event
// flag on any push rise.
//   clk_i : CPU clock
//   rst_i : asynchronous active-high reset
//   bus   : input_debouncer_if slave (raw inputs in, conditioned outputs out)
module input_debouncer
    import io_pkg::*;
#(
    parameter int unsigned N_PUSH          = N_PUSH_DEF,
    parameter int unsigned N_SW            = N_SW_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PRESCALE        = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input_debouncer_if.slave   bus
);

    localparam int unsigned   PS_W    = clog2(PRESCALE + 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]   ps_q, ps_d;
    logic              tick_c;
    logic              event_q, event_d;

    logic [N_PUSH-1:0] push_level;
    logic [N_PUSH-1:0] push_rise;
    logic [N_PUSH-1:0] push_fall;
    logic [N_PUSH-1:0] push_rise_next;
    logic [N_SW-1:0]   sw_level;
    logic [N_SW-1:0]   sw_rise_unused;
    logic [N_SW-1:0]   sw_fall_unused;
    logic [N_SW-1:0]   sw_next_unused;

    // Shared tick generator; with PRESCALE=1 the counter stays at 0 and tick is constant
    always_comb begin
        tick_c = (ps_q == PS_LAST);
        ps_d   = tick_c ? '0 : ps_q + PS_W'(1);
    end

    // Event flop fed by the pulses' next-state so it lines up with push_rise_o
    always_comb begin
        event_d = |push_rise_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ps_q    <= '0;
            event_q <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            event_q <= event_d;
        end
    end

    for (genvar i = 0; i < int'(N_PUSH); i++) begin : g_push
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .tick_i      (tick_c),
            .raw_i       (bus.push_i[i]),
            .level_o     (push_level[i]),
            .rise_o      (push_rise[i]),
            .fall_o      (push_fall[i]),
            .rise_next_c (push_rise_next[i])
        );
    end

    // Switches reuse the same filter; their pulses have no consumer
    for (genvar i = 0; i < int'(N_SW); i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .tick_i      (tick_c),
            .raw_i       (bus.switch_i[i]),
            .level_o     (sw_level[i]),
            .rise_o      (sw_rise_unused[i]),
            .fall_o      (sw_fall_unused[i]),
            .rise_next_c (sw_next_unused[i])
        );
    end

    assign bus.push_level_o   = push_level;
    assign bus.push_rise_o    = push_rise;
    assign bus.push_fall_o    = push_fall;
    assign bus.switch_level_o = sw_level;
    assign bus.event_o        = event_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: DUT A (16-sample window, tick every cycle) and
// DUT B (3-sample window, tick every 4th cycle) are both checked every cycle
// against a behavioural model, plus a level table and directed corner cases.
module tb_input_debouncer;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    input_debouncer_if #(.N_PUSH(10), .N_SW(8)) bus_a ();
    input_debouncer_if #(.N_PUSH(10), .N_SW(8)) bus_b ();

    input_debouncer #(
        .N_PUSH(10), .N_SW(8), .DEBOUNCE_CYCLES(16), .PRESCALE(1)
    ) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    input_debouncer #(
        .N_PUSH(10), .N_SW(8), .DEBOUNCE_CYCLES(3), .PRESCALE(4)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: raw inputs reach the filter two edges late; a bit's
    // level flips once it has disagreed with the level on d consecutive tick
    // samples with no agreeing sample in between. Bits [17:8] push, [7:0] switch.
    typedef struct packed {
        logic [17:0]      h1;
        logic [17:0]      h2;
        logic [17:0]      lvl;
        logic [17:0]      rise;
        logic [17:0]      fall;
        logic             ev;
        logic [17:0][7:0] run;
        logic [31:0]      ncyc;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    function automatic mdl_t mdl_step(input mdl_t m, input logic [17:0] raw, input int d, input int p);
        mdl_t n;
        logic tick;
        n      = m;
        n.rise = '0;
        n.fall = '0;
        tick   = ((m.ncyc % 32'(p)) == 32'(p - 1));
        for (int i = 0; i < 18; i++) begin
            if (m.h2[i] == m.lvl[i]) begin
                n.run[i] = '0;
            end else if (tick) begin
                if (int'(m.run[i]) + 1 >= d) begin
                    n.lvl[i] = m.h2[i];
                    n.run[i] = '0;
                    if (i >= 8) begin
                        n.rise[i] = m.h2[i];
                        n.fall[i] = ~m.h2[i];
                    end
                end else begin
                    n.run[i] = m.run[i] + 8'd1;
                end
            end
        end
        n.ev   = |n.rise[17:8];
        n.h2   = m.h1;
        n.h1   = raw;
        n.ncyc = m.ncyc + 32'd1;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= mdl_step(ma, {bus_a.push_i, bus_a.switch_i}, 16, 1);
            mb <= mdl_step(mb, {bus_b.push_i, bus_b.switch_i}, 3, 4);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_models();
        chk("model_a", 64'({bus_a.push_level_o, bus_a.push_rise_o, bus_a.push_fall_o,
                            bus_a.switch_level_o, bus_a.event_o}),
                       64'({ma.lvl[17:8], ma.rise[17:8], ma.fall[17:8], ma.lvl[7:0], ma.ev}));
        chk("model_b", 64'({bus_b.push_level_o, bus_b.push_rise_o, bus_b.push_fall_o,
                            bus_b.switch_level_o, bus_b.event_o}),
                       64'({mb.lvl[17:8], mb.rise[17:8], mb.fall[17:8], mb.lvl[7:0], mb.ev}));
    endtask

    // Advance n clock edges, sampling on each following falling edge
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_models();
        end
    endtask

    typedef struct {
        logic [9:0] push;
        logic [7:0] sw;
        int         hold;
        logic [9:0] exp_push;
        logic [7:0] exp_sw;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int         n;
        logic [9:0] acc;
        logic       lacc;

        tbl[0] = '{10'h155, 8'h3C, 17, 10'h000, 8'h00};
        tbl[1] = '{10'h155, 8'h3C,  1, 10'h155, 8'h3C};
        tbl[2] = '{10'h2AA, 8'hC3, 30, 10'h2AA, 8'hC3};
        tbl[3] = '{10'h000, 8'h00,  5, 10'h2AA, 8'hC3};
        tbl[4] = '{10'h3FF, 8'hFF, 30, 10'h3FF, 8'hFF};
        tbl[5] = '{10'h000, 8'h00, 17, 10'h3FF, 8'hFF};
        tbl[6] = '{10'h000, 8'h00,  1, 10'h000, 8'h00};

        nvec = 0;
        nerr = 0;
        rst  = 1'b1;
        bus_a.push_i   = 10'h3FF;
        bus_a.switch_i = 8'h00;
        bus_b.push_i   = 10'h000;
        bus_b.switch_i = 8'h00;

        // Reset with inputs already high: no pulse at release, normal filter-up
        step(3);
        chk("reset_outputs", 64'({bus_a.push_level_o, bus_a.push_rise_o, bus_a.push_fall_o,
                                  bus_a.switch_level_o, bus_a.event_o}), 64'd0);
        rst = 1'b0;
        step(17);
        chk("rel_level_e16", 64'({bus_a.push_level_o, bus_a.push_rise_o}), 64'd0);
        step(1);
        chk("rel_level_e17", 64'({bus_a.push_level_o, bus_a.push_rise_o, bus_a.event_o}),
            64'({10'h3FF, 10'h3FF, 1'b1}));
        step(1);
        chk("rel_pulse_end", 64'({bus_a.push_rise_o, bus_a.event_o}), 64'd0);
        bus_a.push_i = 10'h000;
        step(20);
        chk("rel_clear", 64'(bus_a.push_level_o), 64'd0);

        // Level table
        for (int i = 0; i < 7; i++) begin
            bus_a.push_i   = tbl[i].push;
            bus_a.switch_i = tbl[i].sw;
            step(tbl[i].hold);
            chk($sformatf("table_%0d", i), 64'({bus_a.push_level_o, bus_a.switch_level_o}),
                64'({tbl[i].exp_push, tbl[i].exp_sw}));
        end

        // Clean press and release of push[5]
        bus_a.push_i = 10'h020;
        step(17);
        chk("press_e16", 64'(bus_a.push_level_o), 64'd0);
        step(1);
        chk("press_e17", 64'({bus_a.push_level_o, bus_a.push_rise_o, bus_a.push_fall_o, bus_a.event_o}),
            64'({10'h020, 10'h020, 10'h000, 1'b1}));
        step(1);
        chk("press_after", 64'({bus_a.push_level_o, bus_a.push_rise_o, bus_a.event_o}),
            64'({10'h020, 10'h000, 1'b0}));
        bus_a.push_i = 10'h000;
        step(18);
        chk("release_e17", 64'({bus_a.push_level_o, bus_a.push_rise_o, bus_a.push_fall_o, bus_a.event_o}),
            64'({10'h000, 10'h000, 10'h020, 1'b0}));

        // Bounce: 15 high, 1 low, 15 high, low -- never long enough
        acc  = '0;
        lacc = 1'b0;
        for (int k = 0; k < 51; k++) begin
            bus_a.push_i = (k < 15 || (k > 15 && k < 31)) ? 10'h001 : 10'h000;
            step(1);
            acc  = acc | bus_a.push_rise_o | bus_a.push_fall_o;
            lacc = lacc | bus_a.push_level_o[0];
        end
        chk("bounce_pulses", 64'(acc), 64'd0);
        chk("bounce_level", 64'(lacc), 64'd0);

        // Simultaneous rise on bit 9 and fall on bit 1
        bus_a.push_i = 10'h002;
        step(20);
        chk("simul_setup", 64'(bus_a.push_level_o), 64'h002);
        bus_a.push_i = 10'h200;
        step(17);
        chk("simul_e16", 64'(bus_a.push_level_o), 64'h002);
        step(1);
        chk("simul_e17", 64'({bus_a.push_rise_o, bus_a.push_fall_o, bus_a.push_level_o, bus_a.event_o}),
            64'({10'h200, 10'h002, 10'h200, 1'b1}));

        // Toggling every cycle never settles
        for (int k = 0; k < 40; k++) begin
            bus_a.push_i = (k % 2 == 0) ? 10'h204 : 10'h200;
            step(1);
        end
        chk("toggle_level", 64'(bus_a.push_level_o), 64'h200);
        bus_a.push_i = 10'h200;
        step(5);

        // Prescaled switch filter on DUT B
        bus_b.switch_i = 8'hA5;
        n = 0;
        while (bus_b.switch_level_o != 8'hA5 && n < 40) begin
            step(1);
            n++;
        end
        chk("prescale_level", 64'(bus_b.switch_level_o), 64'hA5);
        chk("prescale_window", 64'(n >= 11 && n <= 17), 64'd1);

        // Reset in the middle of a filter window
        bus_a.push_i   = 10'h00F;
        bus_a.switch_i = 8'hFF;
        step(20);
        chk("midrst_setup", 64'({bus_a.push_level_o, bus_a.switch_level_o}), 64'({10'h00F, 8'hFF}));
        bus_a.push_i = 10'h01F;
        step(11);
        #3 rst = 1'b1;
        #1;
        chk("midrst_async_a", 64'({bus_a.push_level_o, bus_a.push_rise_o, bus_a.push_fall_o,
                                   bus_a.switch_level_o, bus_a.event_o}), 64'd0);
        chk("midrst_async_b", 64'({bus_b.push_level_o, bus_b.switch_level_o}), 64'd0);
        step(2);
        rst = 1'b0;
        step(17);
        chk("midrst_e16", 64'({bus_a.push_level_o, bus_a.switch_level_o}), 64'd0);
        step(1);
        chk("midrst_e17", 64'({bus_a.push_level_o, bus_a.push_rise_o, bus_a.switch_level_o, bus_a.event_o}),
            64'({10'h01F, 10'h01F, 8'hFF, 1'b1}));

        // Random segments on both DUTs against the model
        for (int s = 0; s < 80; s++) begin
            bus_a.push_i   = 10'($urandom);
            bus_a.switch_i = 8'($urandom);
            bus_b.push_i   = 10'($urandom);
            bus_b.switch_i = 8'($urandom);
            step(int'($urandom_range(1, 24)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
